// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with level, thresholds and sticky error flags
module fifo_sync_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  EN,
   input  logic                  WR,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  RD,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  VALID,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  ALMOST_EMPTY,
   output logic                  ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   AF_LVL   = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   AE_LVL   = AE_LEVEL[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  empty, full, wr_acc, rd_acc;

   assign empty  = (level_q == '0);
   assign full   = (level_q == LVL_FULL);
   // Accept decisions use the registered level only, so a read never sees a same-cycle write.
   assign wr_acc = EN & WR & ~full;
   assign rd_acc = EN & RD & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      dout_d   = dout_q;
      valid_d  = rd_acc;
      ovf_d    = ovf_q | (EN & WR & full);
      udf_d    = udf_q | (EN & RD & empty);
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage carries no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge Clk) begin
      if (!Rst && wr_acc) mem_q[wr_ptr_q] <= dataIn;
   end

   assign dataOut      = dout_q;
   assign VALID        = valid_q;
   assign EMPTY        = empty;
   assign FULL         = full;
   assign ALMOST_EMPTY = (level_q <= AE_LVL);
   assign ALMOST_FULL  = (level_q >= AF_LVL);
   assign level        = level_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param against a queue model
module tb_fifo_sync_param;

   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AFL   = 6;
   localparam int AEL   = 2;

   logic          Clk = 1'b0;
   logic          Rst, EN, WR, RD;
   logic [DW-1:0] dataIn;
   logic [DW-1:0] dataOut;
   logic          VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW;
   logic [AW:0]   level;

   fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
      .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
      .dataOut(dataOut), .VALID(VALID), .EMPTY(EMPTY), .FULL(FULL),
      .ALMOST_EMPTY(ALMOST_EMPTY), .ALMOST_FULL(ALMOST_FULL), .level(level),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 Clk = ~Clk;

   int nchecks = 0;
   int nerr    = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   logic          m_valid, m_ovf, m_udf;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = mq.size();
      check({tag, ".dataOut"},   64'(dataOut),      64'(m_dout));
      check({tag, ".VALID"},     64'(VALID),        64'(m_valid));
      check({tag, ".level"},     64'(level),        64'(n));
      check({tag, ".EMPTY"},     64'(EMPTY),        64'(n == 0));
      check({tag, ".FULL"},      64'(FULL),         64'(n == DEPTH));
      check({tag, ".AE"},        64'(ALMOST_EMPTY), 64'(n <= AEL));
      check({tag, ".AF"},        64'(ALMOST_FULL),  64'(n >= AFL));
      check({tag, ".OVERFLOW"},  64'(OVERFLOW),     64'(m_ovf));
      check({tag, ".UNDERFLOW"}, 64'(UNDERFLOW),    64'(m_udf));
   endtask

   // One clock: drive inputs, advance the model from pre-edge state, sample after the edge.
   task automatic step(input logic rst, input logic en, input logic wr, input logic rd,
                       input logic [DW-1:0] din);
      bit full_now, empty_now, ra;
      Rst = rst; EN = en; WR = wr; RD = rd; dataIn = din;
      full_now  = (mq.size() == DEPTH);
      empty_now = (mq.size() == 0);
      if (rst) begin
         mq.delete();
         m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else if (!en) begin
         m_valid = 1'b0;
      end else begin
         ra = rd && !empty_now;
         if (wr && full_now)  m_ovf = 1'b1;
         if (rd && empty_now) m_udf = 1'b1;
         if (ra) m_dout = mq.pop_front();
         if (wr && !full_now) mq.push_back(din);
         m_valid = ra;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check_all("reset");
      step(0, 1, 0, 0, 0);
      check_all("idle");
      check("idle.empty_const", 64'(EMPTY), 64'd1);

      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 1, 0, DW'(i * 32'h11));
         check_all("fill");
         check("fill.level_const", 64'(level), 64'(i));
      end
      check("fill.full_const", 64'(FULL), 64'd1);
      step(0, 1, 1, 0, 32'hDEAD);
      check_all("overwrite");
      check("overwrite.ovf_const", 64'(OVERFLOW), 64'd1);
      check("overwrite.level_const", 64'(level), 64'd8);

      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 0, 1, 0);
         check_all("drain");
         check("drain.data_const", 64'(dataOut), 64'(i * 32'h11));
      end
      step(0, 1, 0, 1, 0);
      check_all("overread");
      check("overread.udf_const", 64'(UNDERFLOW), 64'd1);
      check("overread.valid_const", 64'(VALID), 64'd0);
      check("overread.hold_const", 64'(dataOut), 64'h88);

      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, DW'(100 + i));
      check_all("preload");
      for (int i = 3; i < 23; i++) begin
         step(0, 1, 1, 1, DW'(100 + i));
         check_all("stream");
         check("stream.data_const", 64'(dataOut), 64'(100 + i - 3));
      end
      check("stream.level_const", 64'(level), 64'd3);

      step(1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 32'hA5);
      check_all("rw_empty");
      check("rw_empty.level_const", 64'(level), 64'd1);
      check("rw_empty.udf_const", 64'(UNDERFLOW), 64'd1);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, DW'(32'hB0 + i));
      step(0, 1, 1, 1, 32'hCC);
      check_all("rw_full");
      check("rw_full.level_const", 64'(level), 64'd7);
      check("rw_full.ovf_const", 64'(OVERFLOW), 64'd1);
      check("rw_full.data_const", 64'(dataOut), 64'hA5);

      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, DW'(32'h50 + i));
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 32'h60);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, i[0], ~i[0], DW'($urandom));
         check_all("disabled");
      end
      check("disabled.level_const", 64'(level), 64'd5);
      step(0, 1, 1, 1, 32'h70);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 32'h1);
      step(0, 1, 1, 0, 32'h2);
      step(0, 1, 1, 0, 32'h3);
      step(0, 1, 1, 0, 32'h4);
      step(0, 1, 1, 0, 32'h5);
      check("pre_rst.level_const", 64'(level), 64'd5);
      step(1, 1, 1, 1, 32'hFF);
      check_all("mid_reset");
      check("mid_reset.level_const", 64'(level), 64'd0);
      check("mid_reset.udf_const", 64'(UNDERFLOW), 64'd0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), DW'($urandom));
         check_all("random");
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
